// File: rtl/nco_pkg.sv
// Shared types, default geometry and the sine table generator for the NCO.
package nco_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'b00,
    SQUARE = 2'b01,
    SAW    = 2'b10,
    TRI    = 2'b11
  } wave_t;

  localparam int PHASE_W_DEF    = 24;
  localparam int LUT_AW_DEF     = 8;
  localparam int SAMPLE_DIV_DEF = 512;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sd32767;
  localparam int                 FS_HZ      = 48000;

  // round(32767*sin(2*pi*(k+0.5)/2^(aw+2))) in 2^-30 fixed point (Taylor to x^17).
  function automatic logic [14:0] sine_entry(input int k, input int aw);
    longint pi_fx;
    longint x;
    longint x2;
    longint mag;
    longint acc;
    longint res;
    pi_fx = 64'sd3373259426;
    x     = (pi_fx * longint'(2 * k + 1)) >>> (aw + 2);
    x2    = (x * x) >>> 30;
    mag   = x;
    acc   = x;
    for (int n = 1; n <= 8; n++) begin
      mag = ((mag * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) acc = acc - mag;
      else              acc = acc + mag;
    end
    res = (acc * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    return res[14:0];
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with a registered read port; contents are built at elaboration.
module sine_quarter_rom
  import nco_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [14:0]       data_o
);

  localparam int DEPTH = 2 ** LUT_AW;

  logic [14:0] table_w [DEPTH];
  logic [14:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [14:0] ENTRY = sine_entry(k, LUT_AW);
    assign table_w[k] = ENTRY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= table_w[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/nco_sample_generator.sv
// 48 kHz NCO: phase accumulator advanced once per sample tick, three-stage
// waveform pipeline (capture, table read, shape) feeding the I2S sample input.
module nco_sample_generator
  import nco_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_AW     = LUT_AW_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic                freq_load,
  input  logic [1:0]          wave_sel,
  input  logic                enable,
  output logic signed [15:0]  new_sound_sample,
  output logic                sample_strobe
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_w;
  logic [PHASE_W-1:0] shadow_q, active_q, phase_q;

  // Stage 1: only the top 16 phase bits feed any waveform.
  logic [15:0]        phase_s1_q;
  wave_t              wave_s1_q;
  logic               en_s1_q, vld_s1_q;

  logic [LUT_AW-1:0]  idx_w, rom_addr_w;
  logic [14:0]        rom_data_w;

  logic [1:0]         quad_s2_q;
  logic [15:0]        p_s2_q;
  wave_t              wave_s2_q;
  logic               en_s2_q, vld_s2_q;

  logic signed [15:0] sine_pos, wave_val, sample_d, sample_q;
  logic signed [17:0] dbl_w, tri_w;
  logic               strobe_q;

  assign tick_w = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cnt_d  = tick_w ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      phase_q    <= '0;
      phase_s1_q <= '0;
      wave_s1_q  <= SINE;
      en_s1_q    <= 1'b0;
      vld_s1_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      vld_s1_q <= tick_w;
      if (freq_load) shadow_q <= freq_word;
      if (tick_w) begin
        // active_q picks up the pre-load shadow when freq_load lands on the tick
        active_q   <= shadow_q;
        phase_s1_q <= phase_q[PHASE_W-1 -: 16];
        wave_s1_q  <= wave_t'(wave_sel);
        en_s1_q    <= enable;
        if (enable) phase_q <= phase_q + active_q;
      end
    end
  end

  // Odd quadrants run the quarter table backwards.
  assign idx_w      = phase_s1_q[13 -: LUT_AW];
  assign rom_addr_w = phase_s1_q[14] ? ~idx_w : idx_w;

  sine_quarter_rom #(.LUT_AW(LUT_AW)) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_i (rom_addr_w),
    .data_o (rom_data_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quad_s2_q <= '0;
      p_s2_q    <= '0;
      wave_s2_q <= SINE;
      en_s2_q   <= 1'b0;
      vld_s2_q  <= 1'b0;
    end else begin
      quad_s2_q <= phase_s1_q[15:14];
      p_s2_q    <= phase_s1_q;
      wave_s2_q <= wave_s1_q;
      en_s2_q   <= en_s1_q;
      vld_s2_q  <= vld_s1_q;
    end
  end

  assign sine_pos = $signed({1'b0, rom_data_w});
  assign dbl_w    = $signed({2'b00, p_s2_q[14:0], 1'b0});
  assign tri_w    = p_s2_q[15] ? (18'sd32767 - dbl_w) : (dbl_w - 18'sd32768);

  always_comb begin
    wave_val = '0;
    case (wave_s2_q)
      SINE:   wave_val = quad_s2_q[1] ? -sine_pos : sine_pos;
      SQUARE: wave_val = p_s2_q[15] ? -SAMPLE_MAX : SAMPLE_MAX;
      SAW:    wave_val = $signed(p_s2_q ^ 16'h8000);
      TRI:    wave_val = tri_w[15:0];
    endcase
  end

  assign sample_d = en_s2_q ? wave_val : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= vld_s2_q;
      if (vld_s2_q) sample_q <= sample_d;
    end
  end

  assign new_sound_sample = sample_q;
  assign sample_strobe    = strobe_q;

endmodule

// File: tb/tb_nco_sample_generator.sv
// Directed bench for nco_sample_generator: waveform tables plus timing and control corner sequences.
module tb_nco_sample_generator;

  logic               clk = 1'b0;
  logic               rst;
  logic [23:0]        freq_word;
  logic               freq_load;
  logic [1:0]         wave_sel;
  logic               enable;
  logic signed [15:0] new_sound_sample;
  logic               sample_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  nco_sample_generator dut (
    .clk              (clk),
    .rst              (rst),
    .freq_word        (freq_word),
    .freq_load        (freq_load),
    .wave_sel         (wave_sel),
    .enable           (enable),
    .new_sound_sample (new_sound_sample),
    .sample_strobe    (sample_strobe)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [1:0]  wave;
    logic [23:0] freq;
    int          j;
    int          exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [1:0]  wave;
    logic [23:0] freq;
    int          n;
  } grp_t;

  vec_t vecs[$];
  int   cap[64];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(output int cyc, output int smp);
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (!sample_strobe && cyc < 1000);
    if (!sample_strobe) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_timeout: no strobe after %0d cycles, expected one within 512", cyc);
    end
    smp = int'(new_sound_sample);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    freq_load = 1'b0;
    freq_word = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_sample", int'(new_sound_sample), 0);
      check("reset_strobe", int'(sample_strobe), 0);
    end
    rst = 1'b1;
  endtask

  task automatic load_freq(input logic [23:0] f);
    freq_word = f;
    freq_load = 1'b1;
    @(negedge clk);
    freq_load = 1'b0;
  endtask

  function automatic int sine_ref(input logic [23:0] ph);
    int  q;
    int  idx;
    int  a;
    int  m;
    real v;
    q   = int'(ph[23:22]);
    idx = int'(ph[21:14]);
    a   = ((q % 2) == 1) ? 255 - idx : idx;
    v   = 32767.0 * $sin(2.0 * 3.14159265358979 * (real'(a) + 0.5) / 1024.0);
    m   = $rtoi($floor(v + 0.5));
    return (q >= 2) ? -m : m;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sq_exp[9]   = '{32767, 32767, 32767, 32767, -32767, -32767, -32767, -32767, 32767};
    int   saw_exp[17] = '{-32768, -28672, -24576, -20480, -16384, -12288, -8192, -4096, 0,
                          4096, 8192, 12288, 16384, 20480, 24576, 28672, -32768};
    int   tri_exp[17] = '{-32768, -24576, -16384, -8192, 0, 8192, 16384, 24576, 32767,
                          24575, 16383, 8191, -1, -8193, -16385, -24577, -32768};
    grp_t grps[4]     = '{'{2'b00, 24'h040000, 49}, '{2'b01, 24'h200000, 9},
                          '{2'b10, 24'h100000, 17}, '{2'b11, 24'h100000, 17}};
    int   c;
    int   s;

    for (int j = 0; j < 49; j++)
      vecs.push_back('{wave: 2'b00, freq: 24'h040000, j: j,
                       exp: sine_ref(24'(j * 32'h40000)), name: $sformatf("sine_j%0d", j)});
    vecs.push_back('{wave: 2'b00, freq: 24'h040000, j: 0,  exp: 101,    name: "sine_first_entry"});
    vecs.push_back('{wave: 2'b00, freq: 24'h040000, j: 16, exp: 32767,  name: "sine_peak"});
    vecs.push_back('{wave: 2'b00, freq: 24'h040000, j: 48, exp: -32767, name: "sine_trough"});
    for (int j = 0; j < 9; j++)
      vecs.push_back('{wave: 2'b01, freq: 24'h200000, j: j, exp: sq_exp[j], name: $sformatf("square_j%0d", j)});
    for (int j = 0; j < 17; j++)
      vecs.push_back('{wave: 2'b10, freq: 24'h100000, j: j, exp: saw_exp[j], name: $sformatf("saw_j%0d", j)});
    for (int j = 0; j < 17; j++)
      vecs.push_back('{wave: 2'b11, freq: 24'h100000, j: j, exp: tri_exp[j], name: $sformatf("tri_j%0d", j)});

    // Reset behaviour, first-strobe latency, hold and period with freq_word = 0.
    wave_sel = 2'b00;
    enable   = 1'b1;
    do_reset();
    wait_strobe(c, s);
    check("first_strobe_latency", c, 514);
    check("first_sample_idx0", s, 101);
    @(posedge clk);
    @(negedge clk);
    check("strobe_one_cycle", int'(sample_strobe), 0);
    repeat (100) @(negedge clk);
    check("sample_held", int'(new_sound_sample), 101);
    wait_strobe(c, s);
    check("strobe_remaining_gap", c, 512 - 101);
    wait_strobe(c, s);
    check("strobe_period", c, 512);

    // Waveform tables; the first strobe after reset comes from a tick where the
    // active word is still zero, so sample j sits at phase j*freq_word from the second strobe on.
    foreach (grps[g]) begin
      do_reset();
      wave_sel = grps[g].wave;
      load_freq(grps[g].freq);
      wait_strobe(c, s);
      for (int j = 0; j < grps[g].n; j++) begin
        wait_strobe(c, s);
        cap[j] = s;
      end
      foreach (vecs[v])
        if (vecs[v].wave == grps[g].wave && vecs[v].freq == grps[g].freq)
          check(vecs[v].name, cap[vecs[v].j], vecs[v].exp);
    end

    // Mute / resume / freq_load on the tick edge, saw at 0x100000.
    do_reset();
    wave_sel = 2'b10;
    load_freq(24'h100000);
    wait_strobe(c, s);
    wait_strobe(c, s);
    check("seq_s1", s, -32768);
    wait_strobe(c, s);
    check("seq_s2_pre_mute", s, -28672);
    enable = 1'b0;
    wait_strobe(c, s);
    check("mute_s3", s, 0);
    wait_strobe(c, s);
    check("mute_s4_strobe_period", c, 512);
    check("mute_s4", s, 0);
    enable = 1'b1;
    wait_strobe(c, s);
    check("resume_held_phase", s, -24576);
    wait_strobe(c, s);
    check("resume_s6", s, -20480);
    // Next tick edge lies 512 clocks after the tick that produced s6.
    repeat (509) @(posedge clk);
    @(negedge clk);
    freq_word = 24'h200000;
    freq_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    freq_load = 1'b0;
    wait_strobe(c, s);
    check("load_on_tick_s7", s, -16384);
    wait_strobe(c, s);
    check("load_on_tick_s8", s, -12288);
    wait_strobe(c, s);
    check("load_on_tick_old_rate", s, -8192);
    wait_strobe(c, s);
    check("new_rate_s10", s, 0);
    wait_strobe(c, s);
    check("new_rate_s11", s, 8192);

    // Asynchronous reset in the middle of a sample period.
    repeat (200) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midframe_reset_sample", int'(new_sound_sample), 0);
    check("midframe_reset_strobe", int'(sample_strobe), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_strobe(c, s);
    check("post_reset_latency", c, 514);
    check("post_reset_sample", s, -32768);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
